// File: rtl/bram_port_arbiter_if.sv
// Bundle of requester-side and BRAM-side signals for bram_port_arbiter.
// slave: the arbiter; master: whatever drives requests and models the BRAM.
interface bram_port_arbiter_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ADDR_W  = 14,
   parameter int unsigned DATA_W  = 18
) ();
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ-1:0]        we;
   logic [NUM_REQ*ADDR_W-1:0] addr;
   logic [NUM_REQ*DATA_W-1:0] wdata;
   logic [NUM_REQ*2-1:0]      be;
   logic [NUM_REQ-1:0]        gnt;
   logic [DATA_W-1:0]         rdata;
   logic [NUM_REQ-1:0]        rvalid;
   logic [14:0]               mem_addr;
   logic [DATA_W-1:0]         mem_wdata;
   logic                      mem_ren;
   logic                      mem_wen;
   logic [1:0]                mem_be;
   logic [DATA_W-1:0]         mem_rdata;
   logic                      flush;
   logic                      busy;

   modport slave (
      input  req, we, addr, wdata, be, mem_rdata, flush,
      output gnt, rdata, rvalid, mem_addr, mem_wdata, mem_ren, mem_wen, mem_be, busy
   );

   modport master (
      output req, we, addr, wdata, be, mem_rdata, flush,
      input  gnt, rdata, rvalid, mem_addr, mem_wdata, mem_ren, mem_wen, mem_be, busy
   );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one 18-bit BRAM half-port among NUM_REQ requesters.
// Define BRAM_ARB_FLUSH_EN to enable the CLEAR/flush engine and the BUSY output.
module bram_port_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned ADDR_W     = 14,
   parameter int unsigned DATA_W     = 18,
   parameter int unsigned RD_LATENCY = 1,
   parameter int unsigned DEPTH      = 1024
) (
   input  logic               clk,
   input  logic               reset_n,
   bram_port_arbiter_if.slave bus
);
   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic              run_en;
   logic              clr_wr;
   logic [14:0]       clr_addr;
   logic              pipe_empty;

   logic [PTR_W-1:0]  ptr_q;
   logic [PTR_W-1:0]  win;
   logic [PTR_W-1:0]  idx;
   logic              found;
   logic [NUM_REQ-1:0] gnt;
   logic              accept;

   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [1:0]        sel_be;

   logic [14:0]       mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              mem_ren_q;
   logic              mem_wen_q;
   logic [1:0]        mem_be_q;

   logic [NUM_REQ-1:0] pipe_q [RD_LATENCY+1];
   logic [NUM_REQ-1:0] rvalid_q;
   logic [DATA_W-1:0]  rdata_q;

   // First requesting index at or above the pointer, wrapping.
   always_comb begin
      win   = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
         idx = PTR_W'((int'(ptr_q) + k) % int'(NUM_REQ));
         if (!found && bus.req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      gnt = '0;
      if (found && run_en && reset_n) begin
         gnt[win] = 1'b1;
      end
   end

   assign accept    = |gnt;
   assign sel_we    = bus.we[win];
   assign sel_addr  = bus.addr[win*ADDR_W +: ADDR_W];
   assign sel_wdata = bus.wdata[win*DATA_W +: DATA_W];
   assign sel_be    = bus.be[win*2 +: 2];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q <= '0;
      end else if (accept) begin
         ptr_q <= (int'(win) == int'(NUM_REQ) - 1) ? '0 : win + PTR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_ren_q   <= 1'b0;
         mem_wen_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
      end else begin
         mem_ren_q <= 1'b0;
         mem_wen_q <= 1'b0;
         if (clr_wr) begin
            mem_wen_q   <= 1'b1;
            mem_addr_q  <= clr_addr;
            mem_wdata_q <= '0;
            mem_be_q    <= 2'b11;
         end else if (accept) begin
            mem_ren_q   <= ~sel_we;
            mem_wen_q   <= sel_we;
            mem_addr_q  <= 15'(sel_addr);
            mem_wdata_q <= sel_wdata;
            mem_be_q    <= sel_we ? sel_be : 2'b11;
         end
      end
   end

   // One-hot requester ids ride alongside the BRAM latency; the tail strobes RVALID.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s <= int'(RD_LATENCY); s++) begin
            pipe_q[s] <= '0;
         end
         rvalid_q <= '0;
         rdata_q  <= '0;
      end else begin
         pipe_q[0] <= (accept && !sel_we) ? gnt : '0;
         for (int s = 1; s <= int'(RD_LATENCY); s++) begin
            pipe_q[s] <= pipe_q[s-1];
         end
         rvalid_q <= pipe_q[RD_LATENCY];
         if (|pipe_q[RD_LATENCY]) begin
            rdata_q <= bus.mem_rdata;
         end
      end
   end

   always_comb begin
      pipe_empty = 1'b1;
      for (int s = 0; s <= int'(RD_LATENCY); s++) begin
         if (|pipe_q[s]) begin
            pipe_empty = 1'b0;
         end
      end
   end

`ifdef BRAM_ARB_FLUSH_EN
   localparam int unsigned CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {StClear, StDrain, StRun} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StClear;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clr_wr  = 1'b0;
      run_en  = 1'b0;
      unique case (state_q)
         StClear: begin
            clr_wr = 1'b1;
            if (bus.flush) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_W'(DEPTH - 1)) begin
               cnt_d   = '0;
               state_d = StRun;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         // Let in-flight reads return before the clear overwrites memory.
         StDrain: begin
            if (pipe_empty) begin
               cnt_d   = '0;
               state_d = StClear;
            end
         end
         StRun: begin
            if (bus.flush) begin
               state_d = StDrain;
            end else begin
               run_en = 1'b1;
            end
         end
         default: state_d = StRun;
      endcase
   end

   assign clr_addr = 15'(cnt_q);
   assign bus.busy = (state_q != StRun);
`else
   logic unused_flush;

   assign unused_flush = ^{bus.flush, pipe_empty};
   assign run_en       = 1'b1;
   assign clr_wr       = 1'b0;
   assign clr_addr     = '0;
   assign bus.busy     = 1'b0;
`endif

   assign bus.gnt       = gnt;
   assign bus.rvalid    = rvalid_q;
   assign bus.rdata     = rdata_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_ren   = mem_ren_q;
   assign bus.mem_wen   = mem_wen_q;
   assign bus.mem_be    = mem_be_q;
endmodule
